// File: rtl/ram_pkg.sv
// Shared definitions for the RAM responder slice.
//   state_e : FSM state encoding (2 bits)
//   op_e    : captured operation code
//   DEF_ADDR_WIDTH / DEF_DATA_WIDTH : default geometry
//   CNT_WIDTH : width of the access-latency counter
package ram_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int CNT_WIDTH      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

endpackage

// File: rtl/ram_array.sv
// Single-port storage array, DATA_WIDTH x 2**ADDR_WIDTH.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset (clears the read register only)
//   we   : synchronous write enable, writes din to mem[addr]
//   re   : synchronous read enable, loads dout from mem[addr]
//   addr : word address
//   din  : write data
//   dout : registered read data, held between reads
module ram_array
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] dout_r;

  // Storage write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= din;
    end
  end

  // Read register: only a read updates it, so it holds across writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_r <= {DATA_WIDTH{1'b0}};
    end else if (re) begin
      dout_r <= mem_r[addr];
    end
  end

  assign dout = dout_r;

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder for the ram_wr_en/ram_rd_en level-handshake bus.
// Serves one request at a time after LATENCY cycles and holds ram_ready
// until the initiator drops both enables.
// Ports:
//   clk, rst      : clock and asynchronous active-high reset
//   ram_wr_en     : write request level
//   ram_rd_en     : read request level
//   ram_addr      : request address
//   ram_data_in   : write data
//   ram_data_out  : read data, updated only when a read completes
//   ram_ready     : request complete, held while any enable is high
//   busy          : high in BUSY and ACK
//   proto_err     : one-cycle pulse on both enables in IDLE or an abort in BUSY
module ram_responder
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ram_wr_en,
  input  logic                  ram_rd_en,
  input  logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_data_in,
  output logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  ram_ready,
  output logic                  busy,
  output logic                  proto_err
);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $fatal(1, "ram_responder: LATENCY must be in 1..15");
    end
  endgenerate

  localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(LATENCY - 1);

  state_e                 state_r, state_s;
  logic [CNT_WIDTH-1:0]   cnt_r, cnt_s;
  op_e                    op_r;
  logic [ADDR_WIDTH-1:0]  addr_r;
  logic [DATA_WIDTH-1:0]  data_r;
  logic                   ready_r, busy_r, proto_err_r;
  logic                   proto_err_s, capture_s, we_s, re_s;
  logic                   any_en_s;

  assign any_en_s = ram_wr_en | ram_rd_en;

  // Next-state, counter and array-strobe decode.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    proto_err_s = 1'b0;
    capture_s   = 1'b0;
    we_s        = 1'b0;
    re_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ram_wr_en && ram_rd_en) begin
          proto_err_s = 1'b1;
        end else if (any_en_s) begin
          capture_s = 1'b1;
          cnt_s     = CNT_INIT;
          state_s   = ST_BUSY;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // An abort wins over completion so a dropped write never commits.
        if (!any_en_s) begin
          state_s     = ST_IDLE;
          proto_err_s = 1'b1;
        end else if (cnt_r == {CNT_WIDTH{1'b0}}) begin
          state_s = ST_ACK;
          we_s    = (op_r == OP_WRITE);
          re_s    = (op_r == OP_READ);
        end else begin
          cnt_s = cnt_r - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      ST_ACK: begin
        if (!any_en_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_ACK;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, counter and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_WIDTH{1'b0}};
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
      proto_err_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      ready_r     <= (state_s == ST_ACK);
      busy_r      <= (state_s != ST_IDLE);
      proto_err_r <= proto_err_s;
    end
  end

  // Request capture: later input changes during BUSY are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r   <= OP_READ;
      addr_r <= {ADDR_WIDTH{1'b0}};
      data_r <= {DATA_WIDTH{1'b0}};
    end else if (capture_s) begin
      op_r   <= ram_wr_en ? OP_WRITE : OP_READ;
      addr_r <= ram_addr;
      data_r <= ram_data_in;
    end
  end

  ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (we_s),
    .re   (re_s),
    .addr (addr_r),
    .din  (data_r),
    .dout (ram_data_out)
  );

  assign ram_ready = ready_r;
  assign busy      = busy_r;
  assign proto_err = proto_err_r;

endmodule

// File: tb/tb_ram_responder.sv
module tb_ram_responder;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ram_wr_en = 1'b0;
  logic       ram_rd_en = 1'b0;
  logic [7:0] ram_addr = 8'h00;
  logic [7:0] ram_data_in = 8'h00;
  logic [7:0] ram_data_out;
  logic       ram_ready, busy, proto_err;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;   // expected read data (reads only)
  } vec_t;

  vec_t vecs[10];

  ram_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
    .ram_ready(ram_ready), .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Full transaction; caller is at a negedge. Inputs are scrambled after the
  // request is sampled to show the responder uses its captured copies.
  task automatic do_op(input logic wr, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] exp);
    int k;
    bit got;
    logic [7:0] first;
    logic [7:0] want;
    ram_addr = a; ram_data_in = d; ram_wr_en = wr; ram_rd_en = ~wr;
    if (!wr) exp_q.push_back(exp);
    k = 0; got = 1'b0; first = 8'h00;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        ram_addr = ~a; ram_data_in = ~d;
      end
      if (ram_ready) got = 1'b1;
    end
    if (!got) begin
      check("ready_timeout", 32'd0, 32'd1);
    end else begin
      check("latency", k, LAT + 1);
      if (!wr) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        first = ram_data_out;
        check("read_data", first, want);
      end
      @(negedge clk);
      check("ready_hold", ram_ready, 1'b1);
      if (!wr) check("data_stable", ram_data_out, first);
    end
    ram_wr_en = 1'b0; ram_rd_en = 1'b0;
    @(negedge clk);
    check("ready_drop", ram_ready, 1'b0);
    check("busy_drop", busy, 1'b0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'hFF, 8'h3C, 8'h00};
    vecs[1] = '{1'b1, 8'h00, 8'h00, 8'h00};
    vecs[2] = '{1'b0, 8'hFF, 8'h00, 8'h3C};
    vecs[3] = '{1'b0, 8'h00, 8'h00, 8'h00};
    vecs[4] = '{1'b1, 8'h01, 8'h5A, 8'h00};
    vecs[5] = '{1'b0, 8'h01, 8'h00, 8'h5A};
    vecs[6] = '{1'b1, 8'h10, 8'h96, 8'h00};
    vecs[7] = '{1'b0, 8'h10, 8'h00, 8'h96};
    vecs[8] = '{1'b0, 8'hFF, 8'h00, 8'h3C};
    vecs[9] = '{1'b1, 8'h20, 8'h11, 8'h00};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", ram_ready, 1'b0);
    check("rst_data", ram_data_out, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_perr", proto_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Basic write then read-back
    do_op(1'b1, 8'h10, 8'hA5, 8'h00);
    do_op(1'b0, 8'h10, 8'h00, 8'hA5);

    // Table of accesses, including address boundaries 0x00/0xFF
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp);
    end

    // Both enables in IDLE: single proto_err pulse, no access
    ram_addr = 8'h10; ram_data_in = 8'hEE; ram_wr_en = 1'b1; ram_rd_en = 1'b1;
    @(negedge clk);
    check("both_perr", proto_err, 1'b1);
    check("both_busy", busy, 1'b0);
    check("both_ready", ram_ready, 1'b0);
    ram_wr_en = 1'b0; ram_rd_en = 1'b0;
    @(negedge clk);
    check("both_perr_end", proto_err, 1'b0);
    do_op(1'b0, 8'h10, 8'h00, 8'h96);

    // Abort: drop wr_en one cycle into BUSY
    ram_addr = 8'h20; ram_data_in = 8'h77; ram_wr_en = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 1'b1);
    ram_wr_en = 1'b0;
    @(negedge clk);
    check("abort_perr", proto_err, 1'b1);
    check("abort_ready", ram_ready, 1'b0);
    check("abort_idle", busy, 1'b0);
    @(negedge clk);
    check("abort_perr_end", proto_err, 1'b0);
    do_op(1'b0, 8'h20, 8'h00, 8'h11);

    // Async reset during a write's BUSY: outputs clear at once, no commit
    ram_addr = 8'h20; ram_data_in = 8'h55; ram_wr_en = 1'b1;
    @(negedge clk);
    check("rstbusy_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_busy", busy, 1'b0);
    check("async_ready", ram_ready, 1'b0);
    check("async_data", ram_data_out, 8'h00);
    @(negedge clk);
    ram_wr_en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    do_op(1'b0, 8'h20, 8'h00, 8'h11);

    // Back-to-back initiator traffic: writes then reads of distinct addresses
    for (int i = 0; i < 6; i++) begin
      do_op(1'b1, 8'(i * 37 + 3), 8'(i * 29 + 7), 8'h00);
    end
    for (int i = 5; i >= 0; i--) begin
      do_op(1'b0, 8'(i * 37 + 3), 8'h00, 8'(i * 29 + 7));
    end
    check("sb_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
